mc_control_unit_hs: RTL and testbench

//  Multi-cycle RV32I(+M) control FSM with ready-handshake memory and a trap path.

---
 rtl/mc_control_unit_hs.sv | 207 ++++++++++++++++++++
 tb/tb_mc_control_unit_hs.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit_hs.sv
// Multi-cycle RV32I(+M) control FSM. Fetch and data accesses wait on ready handshakes, each wait
// is bounded by a timeout, and any fault parks the core in a sticky trap state.
//
// state    | meaning
// FETCH    | wait for imemReady, then load IR and advance PC
// DECODE   | classify instrCode, pick the execute state or trap
// R_EXE    | register-register ALU op and write-back
// I_EXE    | register-immediate ALU op and write-back
// B_EXE    | branch compare and PC select
// LU_EXE   | LUI write-back
// AU_EXE   | AUIPC write-back
// J_EXE    | JAL: write PC+4, jump
// JL_EXE   | JALR: write PC+4, jump to register target
// S_EXE    | store address compute
// S_MEM    | hold busWe until busReady
// L_EXE    | load address compute
// L_MEM    | hold busRe until busReady
// L_WB     | write loaded data back
// MDU_EXE  | issue one mduStart pulse
// MDU_WAIT | wait for mduDone and write the MDU result back
// TRAP     | halted until reset
module mc_control_unit_hs #(
  parameter int EN_MEXT     = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instrCode,
  input  logic        imemReady,
  input  logic        busReady,
  input  logic        mduDone,
  output logic        PCEn,
  output logic        irWe,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic        busRe,
  output logic        busWe,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic [1:0]  memSize,
  output logic        memUnsigned,
  output logic        mduStart,
  output logic        trap,
  output logic [1:0]  trapCause
);

  typedef enum logic [4:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
    S_EXE, S_MEM, L_EXE, L_MEM, L_WB, MDU_EXE, MDU_WAIT, TRAP
  } state_t;

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT - 1);
  localparam logic            MEXT  = (EN_MEXT != 0);

  state_t          state, state_d;
  logic [TO_W-1:0] cnt;
  logic [1:0]      cause, cause_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       unused_instr;

  assign opcode       = instrCode[6:0];
  assign funct3       = instrCode[14:12];
  assign funct7       = instrCode[31:25];
  assign unused_instr = ^{instrCode[24:15], instrCode[11:7]};

  // Counter restarts on every state change, so each wait state sees a fresh budget.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      cnt   <= '0;
      cause <= 2'b00;
    end else begin
      state <= state_d;
      cause <= cause_d;
      if (state_d != state)
        cnt <= '0;
      else if (state == FETCH || state == S_MEM || state == L_MEM)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    cause_d = cause;
    case (state)
      FETCH: begin
        if (imemReady) state_d = DECODE;
        else if (cnt == LIMIT) begin
          state_d = TRAP;
          cause_d = 2'b10;
        end
      end
      DECODE: begin
        state_d = TRAP;
        cause_d = 2'b01;
        case (opcode)
          7'b0110011: begin
            if (funct7 == 7'b0000000 || funct7 == 7'b0100000) state_d = R_EXE;
            else if (funct7 == 7'b0000001 && MEXT) state_d = MDU_EXE;
          end
          7'b0010011: state_d = I_EXE;
          7'b1100011: state_d = B_EXE;
          7'b0110111: state_d = LU_EXE;
          7'b0010111: state_d = AU_EXE;
          7'b1101111: state_d = J_EXE;
          7'b1100111: state_d = JL_EXE;
          7'b0100011: if (funct3 < 3'b011) state_d = S_EXE;
          7'b0000011: if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) state_d = L_EXE;
          default: state_d = TRAP;
        endcase
        if (state_d != TRAP) cause_d = cause;
      end
      R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE: state_d = FETCH;
      S_EXE: state_d = S_MEM;
      L_EXE: state_d = L_MEM;
      S_MEM, L_MEM: begin
        if (busReady) state_d = (state == S_MEM) ? FETCH : L_WB;
        else if (cnt == LIMIT) begin
          state_d = TRAP;
          cause_d = 2'b11;
        end
      end
      L_WB:     state_d = FETCH;
      MDU_EXE:  state_d = MDU_WAIT;
      MDU_WAIT: if (mduDone) state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    PCEn          = 1'b0;
    irWe          = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = 4'b0000;
    aluSrcMuxSel  = 1'b0;
    busRe         = 1'b0;
    busWe         = 1'b0;
    RFWDSrcMuxSel = 3'b000;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    memSize       = 2'b10;
    memUnsigned   = 1'b0;
    mduStart      = 1'b0;
    trap          = 1'b0;
    trapCause     = cause;
    case (state)
      FETCH: begin
        PCEn = imemReady;
        irWe = imemReady;
      end
      R_EXE: begin
        regFileWe  = 1'b1;
        aluControl = {instrCode[30], funct3};
      end
      I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        aluControl   = (funct3 == 3'b101) ? {instrCode[30], funct3} : {1'b0, funct3};
      end
      B_EXE: begin
        branch     = 1'b1;
        aluControl = {1'b0, funct3};
      end
      LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b010;
      end
      AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b011;
      end
      J_EXE, JL_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b100;
        jal           = 1'b1;
        jalr          = (state == JL_EXE);
      end
      S_EXE, S_MEM, L_EXE, L_MEM, L_WB: begin
        aluSrcMuxSel = 1'b1;
        memSize      = funct3[1:0];
        memUnsigned  = funct3[2];
        busWe        = (state == S_MEM);
        busRe        = (state == L_MEM);
        if (state == L_WB) begin
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = 3'b001;
        end
      end
      MDU_EXE: mduStart = 1'b1;
      MDU_WAIT: begin
        RFWDSrcMuxSel = 3'b101;
        regFileWe     = mduDone;
      end
      TRAP: trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit_hs.sv
// Directed bench for mc_control_unit_hs; a second instance with EN_MEXT=0 shares the stimulus.
module tb_mc_control_unit_hs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instrCode;
  logic        imemReady, busReady, mduDone;

  logic       PCEn, irWe, regFileWe, aluSrcMuxSel, busRe, busWe, branch, jal, jalr;
  logic       memUnsigned, mduStart, trap;
  logic [3:0] aluControl;
  logic [2:0] RFWDSrcMuxSel;
  logic [1:0] memSize, trapCause;

  logic       PCEn0, irWe0, regFileWe0, aluSrcMuxSel0, busRe0, busWe0, branch0, jal0, jalr0;
  logic       memUnsigned0, mduStart0, trap0;
  logic [3:0] aluControl0;
  logic [2:0] RFWDSrcMuxSel0;
  logic [1:0] memSize0, trapCause0;

  int tests  = 0;
  int failed = 0;

  localparam logic [31:0] LW    = {12'h004, 5'd1, 3'b010, 5'd2, 7'b0000011};
  localparam logic [31:0] LHU   = {12'h004, 5'd1, 3'b101, 5'd2, 7'b0000011};
  localparam logic [31:0] LBAD  = {12'h004, 5'd1, 3'b011, 5'd2, 7'b0000011};
  localparam logic [31:0] SB    = {7'd0, 5'd3, 5'd1, 3'b000, 5'd4, 7'b0100011};
  localparam logic [31:0] SUB   = {7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
  localparam logic [31:0] SRAI  = {7'b0100000, 5'd3, 5'd2, 3'b101, 5'd1, 7'b0010011};
  localparam logic [31:0] ADDIN = {12'hC00, 5'd2, 3'b000, 5'd1, 7'b0010011};
  localparam logic [31:0] JALR  = {12'h000, 5'd1, 3'b000, 5'd1, 7'b1100111};
  localparam logic [31:0] LUI   = {20'h12345, 5'd1, 7'b0110111};
  localparam logic [31:0] MUL   = {7'b0000001, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
  localparam logic [31:0] BAD   = 32'h0000_007F;

  always #5 clk = ~clk;

  mc_control_unit_hs #(.EN_MEXT(1), .MEM_TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .instrCode(instrCode), .imemReady(imemReady),
    .busReady(busReady), .mduDone(mduDone), .PCEn(PCEn), .irWe(irWe), .regFileWe(regFileWe),
    .aluControl(aluControl), .aluSrcMuxSel(aluSrcMuxSel), .busRe(busRe), .busWe(busWe),
    .RFWDSrcMuxSel(RFWDSrcMuxSel), .branch(branch), .jal(jal), .jalr(jalr), .memSize(memSize),
    .memUnsigned(memUnsigned), .mduStart(mduStart), .trap(trap), .trapCause(trapCause));

  mc_control_unit_hs #(.EN_MEXT(0), .MEM_TIMEOUT(16), .TO_W(5)) dut_nomext (
    .clk(clk), .reset_n(reset_n), .instrCode(instrCode), .imemReady(imemReady),
    .busReady(busReady), .mduDone(mduDone), .PCEn(PCEn0), .irWe(irWe0), .regFileWe(regFileWe0),
    .aluControl(aluControl0), .aluSrcMuxSel(aluSrcMuxSel0), .busRe(busRe0), .busWe(busWe0),
    .RFWDSrcMuxSel(RFWDSrcMuxSel0), .branch(branch0), .jal(jal0), .jalr(jalr0), .memSize(memSize0),
    .memUnsigned(memUnsigned0), .mduStart(mduStart0), .trap(trap0), .trapCause(trapCause0));

  // Reset released just after a rising edge, so the following negedge is the first FETCH cycle.
  task automatic do_reset();
    reset_n = 1'b0; instrCode = '0; imemReady = 1'b0; busReady = 1'b0; mduDone = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  // One ready FETCH cycle with instr, then returns sampled in the DECODE cycle.
  task automatic fetch_to_decode(input logic [31:0] instr);
    @(negedge clk); instrCode = instr; imemReady = 1'b1;
    @(negedge clk); imemReady = 1'b0; #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; imemReady = 1'b0; busReady = 1'b0; mduDone = 1'b0; instrCode = LW;
    #1;
    tests++; if ({PCEn, irWe, regFileWe, busRe, busWe, mduStart, branch, jal, jalr} !== 9'b0) begin
      failed++; $display("FAIL reset_strobes got=%b exp=0", {PCEn, irWe, regFileWe, busRe, busWe, mduStart, branch, jal, jalr}); end
    tests++; if ({trap, trapCause} !== 3'b000) begin failed++; $display("FAIL reset_trap got=%b exp=000", {trap, trapCause}); end
    tests++; if ({aluControl, memSize, memUnsigned} !== 7'b0000_10_0) begin
      failed++; $display("FAIL reset_defaults got=%b exp=0000100", {aluControl, memSize, memUnsigned}); end
  endtask

  task automatic test_load_word();
    do_reset();
    @(negedge clk); instrCode = LW; imemReady = 1'b1; #1;
    tests++; if ({PCEn, irWe} !== 2'b11) begin failed++; $display("FAIL fetch_strobe got=%b exp=11", {PCEn, irWe}); end
    @(negedge clk); imemReady = 1'b0; #1;
    tests++; if ({PCEn, irWe, regFileWe, busRe} !== 4'b0) begin failed++; $display("FAIL decode_quiet got=%b exp=0000", {PCEn, irWe, regFileWe, busRe}); end
    @(negedge clk); #1;
    tests++; if ({busRe, aluSrcMuxSel, memSize} !== 4'b0110) begin failed++; $display("FAIL lw_exe got=%b exp=0110", {busRe, aluSrcMuxSel, memSize}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); busReady = (i == 3); #1;
      tests++; if ({busRe, regFileWe} !== 2'b10) begin failed++; $display("FAIL lw_mem%0d got=%b exp=10", i, {busRe, regFileWe}); end
    end
    @(negedge clk); busReady = 1'b0; #1;
    tests++; if ({busRe, regFileWe, RFWDSrcMuxSel, memSize} !== 7'b0_1_001_10) begin
      failed++; $display("FAIL lw_wb got=%b exp=0100110", {busRe, regFileWe, RFWDSrcMuxSel, memSize}); end
    @(negedge clk); #1;
    tests++; if ({regFileWe, trap, PCEn} !== 3'b000) begin failed++; $display("FAIL lw_back got=%b exp=000", {regFileWe, trap, PCEn}); end
  endtask

  task automatic test_lhu_sb();
    do_reset();
    fetch_to_decode(LHU);
    @(negedge clk); #1;
    tests++; if ({memSize, memUnsigned} !== 3'b011) begin failed++; $display("FAIL lhu_size got=%b exp=011", {memSize, memUnsigned}); end
    @(negedge clk); busReady = 1'b1; #1;
    tests++; if ({busRe, memSize, memUnsigned} !== 4'b1011) begin failed++; $display("FAIL lhu_mem got=%b exp=1011", {busRe, memSize, memUnsigned}); end
    @(negedge clk); busReady = 1'b0; #1;
    tests++; if ({regFileWe, RFWDSrcMuxSel} !== 4'b1001) begin failed++; $display("FAIL lhu_wb got=%b exp=1001", {regFileWe, RFWDSrcMuxSel}); end
    fetch_to_decode(SB);
    @(negedge clk); #1;
    tests++; if ({busWe, aluSrcMuxSel, memSize, memUnsigned} !== 5'b01000) begin
      failed++; $display("FAIL sb_exe got=%b exp=01000", {busWe, aluSrcMuxSel, memSize, memUnsigned}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); busReady = (i == 2); #1;
      tests++; if ({busWe, memSize, regFileWe} !== 4'b1000) begin failed++; $display("FAIL sb_mem%0d got=%b exp=1000", i, {busWe, memSize, regFileWe}); end
    end
    @(negedge clk); busReady = 1'b0; #1;
    tests++; if ({busWe, memSize, PCEn} !== 4'b0100) begin failed++; $display("FAIL sb_done got=%b exp=0100", {busWe, memSize, PCEn}); end
  endtask

  task automatic test_alu_jump();
    do_reset();
    fetch_to_decode(SUB);
    @(negedge clk); #1;
    tests++; if ({regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel} !== 9'b1_0_1000_000) begin
      failed++; $display("FAIL sub got=%b exp=101000000", {regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel}); end
    fetch_to_decode(SRAI);
    @(negedge clk); #1;
    tests++; if ({regFileWe, aluSrcMuxSel, aluControl} !== 6'b11_1101) begin
      failed++; $display("FAIL srai got=%b exp=111101", {regFileWe, aluSrcMuxSel, aluControl}); end
    fetch_to_decode(ADDIN);
    @(negedge clk); #1;
    tests++; if ({regFileWe, aluSrcMuxSel, aluControl} !== 6'b11_0000) begin
      failed++; $display("FAIL addi_neg got=%b exp=110000", {regFileWe, aluSrcMuxSel, aluControl}); end
    fetch_to_decode(JALR);
    @(negedge clk); #1;
    tests++; if ({regFileWe, RFWDSrcMuxSel, jal, jalr, branch} !== 7'b1_100_110) begin
      failed++; $display("FAIL jalr got=%b exp=1100110", {regFileWe, RFWDSrcMuxSel, jal, jalr, branch}); end
    fetch_to_decode(LUI);
    @(negedge clk); #1;
    tests++; if ({regFileWe, RFWDSrcMuxSel, jal} !== 5'b1_010_0) begin
      failed++; $display("FAIL lui got=%b exp=10100", {regFileWe, RFWDSrcMuxSel, jal}); end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); imemReady = 1'b0; #1;
      tests++; if ({PCEn, trap} !== 2'b00) begin failed++; $display("FAIL fto_wait%0d got=%b exp=00", i, {PCEn, trap}); end
    end
    @(negedge clk); imemReady = 1'b1; #1;
    tests++; if ({trap, trapCause, PCEn, irWe} !== 5'b11000) begin
      failed++; $display("FAIL fto_trap got=%b exp=11000", {trap, trapCause, PCEn, irWe}); end
    repeat (3) @(negedge clk); #1;
    tests++; if ({trap, trapCause} !== 3'b110) begin failed++; $display("FAIL fto_sticky got=%b exp=110", {trap, trapCause}); end
  endtask

  task automatic test_fetch_limit();
    do_reset();
    instrCode = ADDIN;
    for (int i = 0; i < 15; i++) begin @(negedge clk); imemReady = 1'b0; end
    @(negedge clk); imemReady = 1'b1; #1;
    tests++; if ({PCEn, trap} !== 2'b10) begin failed++; $display("FAIL flim_ready got=%b exp=10", {PCEn, trap}); end
    @(negedge clk); imemReady = 1'b0; #1;
    tests++; if (trap !== 1'b0) begin failed++; $display("FAIL flim_notrap got=%b exp=0", trap); end
  endtask

  task automatic test_data_timeout();
    do_reset();
    fetch_to_decode(LW);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); busReady = 1'b0; #1;
      tests++; if ({busRe, trap} !== 2'b10) begin failed++; $display("FAIL dto_wait%0d got=%b exp=10", i, {busRe, trap}); end
    end
    @(negedge clk); #1;
    tests++; if ({trap, trapCause, busRe} !== 4'b1110) begin failed++; $display("FAIL dto_trap got=%b exp=1110", {trap, trapCause, busRe}); end
  endtask

  task automatic test_illegal();
    do_reset();
    fetch_to_decode(BAD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests++; if ({trap, trapCause, regFileWe, busWe} !== 5'b10100) begin
        failed++; $display("FAIL illegal%0d got=%b exp=10100", i, {trap, trapCause, regFileWe, busWe}); end
    end
    do_reset();
    @(negedge clk); #1;
    tests++; if ({trap, trapCause} !== 3'b000) begin failed++; $display("FAIL trap_clear got=%b exp=000", {trap, trapCause}); end
    fetch_to_decode(LBAD);
    @(negedge clk); #1;
    tests++; if ({trap, trapCause, busRe} !== 4'b1010) begin failed++; $display("FAIL load_f3 got=%b exp=1010", {trap, trapCause, busRe}); end
  endtask

  task automatic test_mdu();
    do_reset();
    fetch_to_decode(MUL);
    @(negedge clk); #1;
    tests++; if ({mduStart, regFileWe} !== 2'b10) begin failed++; $display("FAIL mdu_start got=%b exp=10", {mduStart, regFileWe}); end
    tests++; if ({trap0, trapCause0, mduStart0} !== 4'b1010) begin
      failed++; $display("FAIL nomext_trap got=%b exp=1010", {trap0, trapCause0, mduStart0}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mduDone = (i == 4); #1;
      if (i < 4) begin
        tests++; if ({mduStart, regFileWe} !== 2'b00) begin failed++; $display("FAIL mdu_wait%0d got=%b exp=00", i, {mduStart, regFileWe}); end
      end else begin
        tests++; if ({mduStart, regFileWe, RFWDSrcMuxSel} !== 5'b01101) begin
          failed++; $display("FAIL mdu_done got=%b exp=01101", {mduStart, regFileWe, RFWDSrcMuxSel}); end
      end
    end
    @(negedge clk); mduDone = 1'b0; #1;
    tests++; if ({regFileWe, mduStart, trap} !== 3'b000) begin failed++; $display("FAIL mdu_back got=%b exp=000", {regFileWe, mduStart, trap}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch_to_decode(LW);
    @(negedge clk);
    @(negedge clk); busReady = 1'b0; #1;
    tests++; if (busRe !== 1'b1) begin failed++; $display("FAIL rmid_pre got=%b exp=1", busRe); end
    #1 reset_n = 1'b0; #1;
    tests++; if ({busRe, trap, regFileWe} !== 3'b000) begin failed++; $display("FAIL rmid_drop got=%b exp=000", {busRe, trap, regFileWe}); end
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk); imemReady = 1'b1; #1;
    tests++; if ({PCEn, irWe, busRe} !== 3'b110) begin failed++; $display("FAIL rmid_fetch got=%b exp=110", {PCEn, irWe, busRe}); end
    imemReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_lhu_sb();
    test_alu_jump();
    test_fetch_timeout();
    test_fetch_limit();
    test_data_timeout();
    test_illegal();
    test_mdu();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
